// File: rtl/mod_det_seq.sv
// Sequential determinant engine for 2x2/3x3/4x4 signed matrices using the
// Leibniz expansion, one permutation term per clock into a wide accumulator.
module mod_det_seq #(
  parameter  int DATA_W = 8,
  parameter  int RES_W  = 16,
  localparam int ACC_W  = 4 * DATA_W + 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [16*DATA_W-1:0]     mat_in,
  output logic signed [RES_W-1:0]  result,
  output logic                     done,
  output logic                     busy,
  output logic                     ovf,
  output logic                     err
);

  typedef enum logic [1:0] {IDLE, ACC, FIN} state_t;

  localparam int ENT_W = 9;  // {sign, p[3], p[2], p[1], p[0]}

  localparam logic signed [ACC_W-1:0] RES_MAX =
    {{(ACC_W-RES_W+1){1'b0}}, {(RES_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] RES_MIN =
    {{(ACC_W-RES_W+1){1'b1}}, {(RES_W-1){1'b0}}};

  // Permutations ordered so that the first 2 only move rows 0..1 and the first
  // 6 only move rows 0..2; smaller sizes then use a prefix of the same table.
  function automatic logic [24*ENT_W-1:0] build_perm_tab();
    logic [24*ENT_W-1:0] tab;
    logic [3:0][1:0]     p;
    logic                ok;
    int                  n;
    int                  sup;
    int                  inv;
    tab = '0;
    n   = 0;
    for (int lvl = 2; lvl <= 4; lvl++) begin
      for (int v = 0; v < 256; v++) begin
        p  = v[7:0];
        ok = 1'b1;
        for (int i = 0; i < 4; i++)
          for (int j = i + 1; j < 4; j++)
            if (p[i] == p[j]) ok = 1'b0;
        sup = 2;
        for (int k = 0; k < 4; k++)
          if (p[k] != 2'(k)) sup = (k + 1 > 2) ? k + 1 : 2;
        if (ok && sup == lvl && n < 24) begin
          inv = 0;
          for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
              if (p[i] > p[j]) inv++;
          tab[n*ENT_W +: ENT_W] = {inv[0], p};
          n++;
        end
      end
    end
    return tab;
  endfunction

  localparam logic [24*ENT_W-1:0] PERM_TAB = build_perm_tab();

  state_t                    state, state_nxt;
  logic [16*DATA_W-1:0]      mat_q;
  logic [1:0]                mode_q;
  logic [4:0]                cnt;
  logic [4:0]                k_last;
  logic                      err_pend;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   term;
  logic                      term_neg;
  logic signed [RES_W-1:0]   res_nxt;
  logic                      ovf_nxt;

  always_comb begin
    case (mode_q)
      2'd0:    k_last = 5'd1;
      2'd1:    k_last = 5'd5;
      default: k_last = 5'd23;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (mode == 2'd3) ? FIN : ACC;
      ACC:     if (cnt == k_last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Rows at or beyond the active size contribute a factor of 1; the table maps
  // them to themselves, so only the active NxN block is ever read.
  always_comb begin
    logic [ENT_W-1:0]        ent;
    logic [1:0]              col;
    logic [DATA_W-1:0]       e;
    logic signed [ACC_W-1:0] f;
    logic [2:0]              n_rows;
    ent      = PERM_TAB[int'(cnt)*ENT_W +: ENT_W];
    term_neg = ent[8];
    n_rows   = {1'b0, mode_q} + 3'd2;
    term     = ACC_W'(1);
    for (int r = 0; r < 4; r++) begin
      col = ent[r*2 +: 2];
      e   = mat_q[(r*4 + int'(col))*DATA_W +: DATA_W];
      if (r < int'(n_rows)) f = {{(ACC_W-DATA_W){e[DATA_W-1]}}, e};
      else                  f = ACC_W'(1);
      term = term * f;
    end
  end

  always_comb begin
    res_nxt = '0;
    ovf_nxt = 1'b0;
    if (!err_pend) begin
      if (acc > RES_MAX) begin
        res_nxt = RES_MAX[RES_W-1:0];
        ovf_nxt = 1'b1;
      end else if (acc < RES_MIN) begin
        res_nxt = RES_MIN[RES_W-1:0];
        ovf_nxt = 1'b1;
      end else begin
        res_nxt = acc[RES_W-1:0];
      end
    end
  end

  // NOTE: the latched matrix is pure data qualified by the FSM, so it carries
  // no reset; every run overwrites it before the first term reads it.
  always_ff @(posedge clk) begin
    if (state == IDLE && start && mode != 2'd3) mat_q <= mat_in;
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, matching the combinational next-state logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      mode_q   <= '0;
      err_pend <= 1'b0;
      result   <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (mode != 2'd3) begin
              mode_q   <= mode;
              acc      <= '0;
              cnt      <= '0;
              err_pend <= 1'b0;
            end else begin
              err_pend <= 1'b1;
            end
          end
        end
        ACC: begin
          acc <= term_neg ? acc - term : acc + term;
          cnt <= cnt + 5'd1;
        end
        FIN: begin
          done   <= 1'b1;
          busy   <= 1'b0;
          result <= res_nxt;
          ovf    <= ovf_nxt;
          err    <= err_pend;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_det_seq.sv
// Directed bench for mod_det_seq: hand-computed determinants, latency, busy
// span, saturation, invalid mode, reset abort and back-to-back operation.
module tb_mod_det_seq;

  localparam int DATA_W = 8;
  localparam int RES_W  = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [1:0]              mode;
  logic [16*DATA_W-1:0]    mat_in;
  logic signed [RES_W-1:0] result;
  logic                    done;
  logic                    busy;
  logic                    ovf;
  logic                    err;

  int errors = 0;
  int checks = 0;
  int m[16];

  always #5 clk = ~clk;

  mod_det_seq #(.DATA_W(DATA_W), .RES_W(RES_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .mat_in (mat_in),
    .result (result),
    .done   (done),
    .busy   (busy),
    .ovf    (ovf),
    .err    (err)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_m();
    for (int i = 0; i < 16; i++) mat_in[i*DATA_W +: DATA_W] = DATA_W'(m[i]);
  endtask

  // Waits for done after an accept edge; returns cycles to done and busy span.
  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = busy ? 1 : 0;
    while (!done && n < 100) begin
      tick();
      n++;
      if (busy) nb++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] md, input int k,
                     input longint exp_res, input logic exp_ovf, input logic exp_err);
    int n, nb;
    mode  = md;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, nb);
    check({tag, "_latency"}, n, k + 1);
    check({tag, "_busy_span"}, nb, k + 1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_ovf"}, ovf, exp_ovf);
    check({tag, "_err"}, err, exp_err);
    tick();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    int n, nb, dn;
    rst    = 1'b1;
    start  = 1'b0;
    mode   = 2'd0;
    mat_in = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_err", err, 0);

    m = '{1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,1};
    load_m();
    run("ident4", 2'd2, 24, 1, 1'b0, 1'b0);

    m = '{2,0,1,127, 1,3,2,127, 1,1,2,127, 127,127,127,127};
    load_m();
    run("m3x3", 2'd1, 6, 6, 1'b0, 1'b0);

    m = '{-128,127,5,5, 127,-128,5,5, 5,5,5,5, 5,5,5,5};
    load_m();
    run("m2x2", 2'd0, 2, 255, 1'b0, 1'b0);

    m = '{-128,0,0,0, 0,-128,0,0, 0,0,-128,0, 0,0,0,-128};
    load_m();
    run("sat_pos", 2'd2, 24, 32767, 1'b1, 1'b0);

    m = '{-128,0,0,0, 0,-128,0,0, 0,0,-128,0, 0,0,0,127};
    load_m();
    run("sat_neg", 2'd2, 24, -32768, 1'b1, 1'b0);

    run("mode3", 2'd3, 0, 0, 1'b0, 1'b1);

    m = '{-128,127,5,5, 127,-128,5,5, 5,5,5,5, 5,5,5,5};
    load_m();
    run("clr_err", 2'd0, 2, 255, 1'b0, 1'b0);

    // Abort a 4x4 run with reset partway through.
    m = '{1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,1};
    load_m();
    mode  = 2'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    dn = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (done) dn++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    check("abort_done", done, 0);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done || busy) dn++;
    end
    check("abort_no_done", dn, 0);
    m = '{-128,127,5,5, 127,-128,5,5, 5,5,5,5, 5,5,5,5};
    load_m();
    run("post_abort", 2'd0, 2, 255, 1'b0, 1'b0);

    // start held high; matrix changes mid-run; second run starts in done cycle.
    m = '{3,1,0,0, 2,5,0,0, 0,0,0,0, 0,0,0,0};
    load_m();
    mode  = 2'd0;
    start = 1'b1;
    tick();
    tick();
    m = '{4,2,0,0, 1,3,0,0, 0,0,0,0, 0,0,0,0};
    load_m();
    n  = 1;
    nb = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check("b2b_first_latency", n, 3);
    check("b2b_first_result", result, 13);
    tick();
    check("b2b_second_busy", busy, 1);
    wait_done(n, nb);
    start = 1'b0;
    check("b2b_second_latency", n, 3);
    check("b2b_second_result", result, 10);
    check("b2b_second_err", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
